// File: rtl/ac_unit.sv
// Accumulator/extension unit: single-cycle ALU and flag ops on {E,AC}, plus
// multi-cycle N-step rotates of the W+1-bit ring sequenced by a two-state FSM.
module ac_unit #(
    parameter int W  = 16,
    parameter int SW = 5
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          START,
    input  logic [3:0]    OP,
    input  logic [W-1:0]  DATA,
    input  logic [SW-1:0] AMT,
    output logic [W-1:0]  Q,
    output logic          E,
    output logic          BUSY,
    output logic          DONE,
    output logic          ZERO,
    output logic          SIGN
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LDA   = 4'd1,
        OP_ADD   = 4'd2,
        OP_AND   = 4'd3,
        OP_CLA   = 4'd4,
        OP_CLE   = 4'd5,
        OP_CMA   = 4'd6,
        OP_CME   = 4'd7,
        OP_CIR   = 4'd8,
        OP_CIL   = 4'd9,
        OP_INC   = 4'd10,
        OP_ROR_N = 4'd11,
        OP_ROL_N = 4'd12
    } opcode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  ac_q, ac_d;
    logic          e_q, e_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;      // 1 = rotate left
    logic          done_q, done_d;

    logic          accept;
    logic          is_rot_op;
    logic          amt_zero;
    logic          last_step;
    logic [W-1:0]  ror_ac, rol_ac;
    logic          ror_e, rol_e;
    logic [W:0]    add_sum;

    // While CLR is high every flop is held in reset, so START cannot be accepted.
    assign accept    = START && (state_q == IDLE);
    assign is_rot_op = (OP == OP_ROR_N) || (OP == OP_ROL_N);
    assign amt_zero  = (AMT == '0);
    assign last_step = (cnt_q == SW'(1));

    // One step of the {E,AC} ring in each direction.
    assign ror_ac  = {e_q, ac_q[W-1:1]};
    assign ror_e   = ac_q[0];
    assign rol_ac  = {ac_q[W-2:0], e_q};
    assign rol_e   = ac_q[W-1];
    assign add_sum = {1'b0, ac_q} + {1'b0, DATA};

    // State register: all architectural state, asynchronously cleared.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            ac_q    <= '0;
            e_q     <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            ac_q    <= ac_d;
            e_q     <= e_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_rot_op && !amt_zero) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: single-cycle ops at the accept edge, one ring step per SHIFT edge.
    always_comb begin
        ac_d   = ac_q;
        e_d    = e_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        done_d = 1'b0;
        if (state_q == SHIFT) begin
            if (dir_q) begin
                ac_d = rol_ac;
                e_d  = rol_e;
            end else begin
                ac_d = ror_ac;
                e_d  = ror_e;
            end
            cnt_d  = cnt_q - SW'(1);
            done_d = last_step;
        end else if (accept) begin
            done_d = 1'b1;
            case (OP)
                OP_LDA: ac_d = DATA;
                OP_ADD: {e_d, ac_d} = add_sum;
                OP_AND: ac_d = ac_q & DATA;
                OP_CLA: ac_d = '0;
                OP_CLE: e_d = 1'b0;
                OP_CMA: ac_d = ~ac_q;
                OP_CME: e_d = ~e_q;
                OP_CIR: begin
                    ac_d = ror_ac;
                    e_d  = ror_e;
                end
                OP_CIL: begin
                    ac_d = rol_ac;
                    e_d  = rol_e;
                end
                OP_INC: ac_d = ac_q + W'(1);
                OP_ROR_N, OP_ROL_N: begin
                    // A zero count degenerates to NOP with a normal DONE pulse.
                    if (!amt_zero) begin
                        cnt_d  = AMT;
                        dir_d  = (OP == OP_ROL_N);
                        done_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        Q    = ac_q;
        E    = e_q;
        BUSY = (state_q == SHIFT);
        DONE = done_q;
        ZERO = (ac_q == '0);
        SIGN = ac_q[W-1];
    end

endmodule

// File: tb/tb_ac_unit.sv
// Directed bench for ac_unit (W=16): a reference model pushes expected results
// to a scoreboard at issue time; they are popped and compared when DONE fires.
module tb_ac_unit;

    localparam logic [3:0] NOP = 4'd0,  LDA = 4'd1,  ADD = 4'd2,  ANDOP = 4'd3;
    localparam logic [3:0] CLA = 4'd4,  CLE = 4'd5,  CMA = 4'd6,  CME = 4'd7;
    localparam logic [3:0] CIR = 4'd8,  CIL = 4'd9,  INC = 4'd10, RORN = 4'd11;
    localparam logic [3:0] ROLN = 4'd12, RSV = 4'd13;

    logic        CLK, CLR, START;
    logic [3:0]  OP;
    logic [15:0] DATA;
    logic [4:0]  AMT;
    logic [15:0] Q;
    logic        E, BUSY, DONE, ZERO, SIGN;

    typedef struct {
        string       tag;
        logic [15:0] q;
        logic        e;
        int          busy;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_ac;
    logic        m_e;
    int          tests = 0;
    int          fails = 0;

    ac_unit #(.W(16), .SW(5)) dut (
        .CLK(CLK), .CLR(CLR), .START(START), .OP(OP), .DATA(DATA), .AMT(AMT),
        .Q(Q), .E(E), .BUSY(BUSY), .DONE(DONE), .ZERO(ZERO), .SIGN(SIGN)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, update the model, then wait (bounded) for DONE and score it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] d,
                          input logic [4:0] a, input bit poke);
        exp_t        x;
        logic [16:0] ring;
        int          steps;
        int          busy_cnt;
        int          waited;

        ring  = {m_e, m_ac};
        steps = 0;
        case (op)
            LDA:   m_ac = d;
            ADD:   {m_e, m_ac} = {1'b0, m_ac} + {1'b0, d};
            ANDOP: m_ac = m_ac & d;
            CLA:   m_ac = '0;
            CLE:   m_e = 1'b0;
            CMA:   m_ac = ~m_ac;
            CME:   m_e = ~m_e;
            CIR, CIL:   steps = 1;
            INC:   m_ac = m_ac + 16'd1;
            RORN, ROLN: steps = int'(a);
            default: ;
        endcase
        for (int i = 0; i < steps; i++) begin
            if (op == CIR || op == RORN) ring = {ring[0], ring[16:1]};
            else                         ring = {ring[15:0], ring[16]};
        end
        if (steps > 0) {m_e, m_ac} = ring;

        x.tag  = tag;
        x.q    = m_ac;
        x.e    = m_e;
        x.busy = ((op == RORN || op == ROLN) && a != 0) ? int'(a) : 0;
        sb.push_back(x);

        START = 1'b1; OP = op; DATA = d; AMT = a;
        @(posedge CLK); #1;
        START = 1'b0;
        OP = 4'($urandom); DATA = 16'($urandom); AMT = 5'($urandom);

        busy_cnt = 0;
        waited   = 0;
        while (DONE !== 1'b1 && waited < 100) begin
            if (BUSY === 1'b1) busy_cnt++;
            if (poke) begin
                START = BUSY;
                OP    = CLA;
            end
            @(posedge CLK); #1;
            waited++;
        end
        START = 1'b0;
        check({tag, ".done"}, 32'(DONE), 32'd1);

        x = sb.pop_front();
        check({x.tag, ".q"},    32'(Q),    32'(x.q));
        check({x.tag, ".e"},    32'(E),    32'(x.e));
        check({x.tag, ".busy"}, busy_cnt,  x.busy);
        check({x.tag, ".zero"}, 32'(ZERO), 32'(x.q == 16'd0));
        check({x.tag, ".sign"}, 32'(SIGN), 32'(x.q[15]));
        check({x.tag, ".bsy0"}, 32'(BUSY), 32'd0);

        @(posedge CLK); #1;
        check({x.tag, ".pulse"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        CLK = 1'b0; CLR = 1'b1;
        START = 1'b1; OP = LDA; DATA = 16'hBEEF; AMT = '0;
        m_ac = '0; m_e = 1'b0;

        // START held during reset must be ignored.
        repeat (3) @(posedge CLK);
        #1;
        check("rst.q",    32'(Q),    32'd0);
        check("rst.e",    32'(E),    32'd0);
        check("rst.busy", 32'(BUSY), 32'd0);
        check("rst.done", 32'(DONE), 32'd0);
        check("rst.zero", 32'(ZERO), 32'd1);
        check("rst.sign", 32'(SIGN), 32'd0);
        START = 1'b0;
        CLR   = 1'b0;

        // Add with carry-out into E.
        run_op("lda_ff",   LDA,   16'h00FF, 5'd0, 1'b0);
        run_op("add_cy",   ADD,   16'hFF01, 5'd0, 1'b0);
        // INC wraps and leaves E=1 untouched.
        run_op("lda_ffff", LDA,   16'hFFFF, 5'd0, 1'b0);
        run_op("inc_wrap", INC,   16'h0000, 5'd0, 1'b0);
        // Single-step rotates through E.
        run_op("cle",      CLE,   16'h0000, 5'd0, 1'b0);
        run_op("lda_1",    LDA,   16'h0001, 5'd0, 1'b0);
        run_op("cir",      CIR,   16'h0000, 5'd0, 1'b0);
        run_op("cil",      CIL,   16'h0000, 5'd0, 1'b0);
        // Logic ops, flag ops, NOP-like codes.
        run_op("lda_c3",   LDA,   16'hC3A5, 5'd0, 1'b0);
        run_op("and",      ANDOP, 16'hF00F, 5'd0, 1'b0);
        run_op("cma",      CMA,   16'h0000, 5'd0, 1'b0);
        run_op("cme",      CME,   16'h0000, 5'd0, 1'b0);
        run_op("nop",      NOP,   16'h1111, 5'd0, 1'b0);
        run_op("rsv13",    RSV,   16'h2222, 5'd0, 1'b0);
        run_op("rsv15",    4'd15, 16'h3333, 5'd0, 1'b0);
        run_op("ror0",     RORN,  16'h4444, 5'd0, 1'b0);
        run_op("cla",      CLA,   16'h0000, 5'd0, 1'b0);
        // Multi-cycle rotate with an ignored CLA during BUSY.
        run_op("lda_1234", LDA,   16'h1234, 5'd0, 1'b0);
        run_op("cle2",     CLE,   16'h0000, 5'd0, 1'b0);
        run_op("ror4",     RORN,  16'h0000, 5'd4, 1'b1);
        // Full-ring rotation returns the original value.
        run_op("lda_a5",   LDA,   16'hA5A5, 5'd0, 1'b0);
        run_op("cme2",     CME,   16'h0000, 5'd0, 1'b0);
        run_op("rol17",    ROLN,  16'h0000, 5'd17, 1'b0);
        run_op("rol3",     ROLN,  16'h0000, 5'd3, 1'b0);
        run_op("ror31",    RORN,  16'h0000, 5'd31, 1'b0);

        // CLR in the second SHIFT cycle aborts immediately, no DONE.
        run_op("lda_5a",   LDA,   16'h5A5A, 5'd0, 1'b0);
        START = 1'b1; OP = RORN; AMT = 5'd8; DATA = '0;
        @(posedge CLK); #1;
        START = 1'b0;
        check("abort.busy1", 32'(BUSY), 32'd1);
        @(posedge CLK); #3;
        CLR = 1'b1;
        #1;
        check("abort.q",    32'(Q),    32'd0);
        check("abort.e",    32'(E),    32'd0);
        check("abort.busy", 32'(BUSY), 32'd0);
        check("abort.done", 32'(DONE), 32'd0);
        #1;
        CLR  = 1'b0;
        m_ac = '0;
        m_e  = 1'b0;
        run_op("lda_42",   LDA,   16'h0042, 5'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
